// File: rtl/crc_mc_pkg.sv
// Shared encodings, reset constants, queue-entry layout and bit helpers for the multi-channel CRC unit.
package crc_mc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] PS_32 = 2'b00;
  localparam logic [1:0] PS_16 = 2'b01;
  localparam logic [1:0] PS_8  = 2'b10;
  localparam logic [1:0] PS_7  = 2'b11;

  localparam logic [1:0] REV_NONE = 2'b00;
  localparam logic [1:0] REV_BYTE = 2'b01;
  localparam logic [1:0] REV_HALF = 2'b10;
  localparam logic [1:0] REV_WORD = 2'b11;

  localparam logic [31:0] RST_POLY  = 32'h04C1_1DB7;
  localparam logic [1:0]  RST_PSIZE = PS_32;
  localparam logic [31:0] RST_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_CRC   = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_XOR   = 32'h0000_0000;

  // Channel field is sized for up to 256 contexts; the top keeps only CH_W bits.
  localparam int ENTRY_CH_W = 8;

  typedef enum logic {
    CMD_DATA  = 1'b0,
    CMD_RESET = 1'b1
  } cmd_e;

  typedef struct packed {
    cmd_e                  cmd;
    logic [ENTRY_CH_W-1:0] ch;
    logic [31:0]           data;
    logic [1:0]            size;
    logic [1:0]            rev;
  } entry_t;

  function automatic logic [31:0] width_mask(input logic [1:0] psize);
    case (psize)
      PS_32:   return 32'hFFFF_FFFF;
      PS_16:   return 32'h0000_FFFF;
      PS_8:    return 32'h0000_00FF;
      PS_7:    return 32'h0000_007F;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] top_bit(input logic [1:0] psize);
    case (psize)
      PS_32:   return 32'h8000_0000;
      PS_16:   return 32'h0000_8000;
      PS_8:    return 32'h0000_0080;
      PS_7:    return 32'h0000_0040;
      default: return 32'h8000_0000;
    endcase
  endfunction

  function automatic logic [5:0] width_bits(input logic [1:0] psize);
    case (psize)
      PS_32:   return 6'd32;
      PS_16:   return 6'd16;
      PS_8:    return 6'd8;
      PS_7:    return 6'd7;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

  // Whole-word reversal mirrors across the transfer size so the valid bytes stay in the low lanes.
  function automatic logic [31:0] in_reverse(input logic [31:0] d, input logic [1:0] size,
                                             input logic [1:0] rev);
    logic [31:0] r;
    int          span;
    r = 32'h0;
    case (size)
      SZ_BYTE: span = 8;
      SZ_HALF: span = 16;
      default: span = 32;
    endcase
    for (int i = 0; i < 32; i++) begin
      case (rev)
        REV_BYTE: r[i] = d[(i & ~7) + 7 - (i & 7)];
        REV_HALF: r[i] = d[(i & ~15) + 15 - (i & 15)];
        REV_WORD: begin
          if (i < span) r[i] = d[span - 1 - i];
          else          r[i] = 1'b0;
        end
        default:  r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational one-byte LFSR update for a CRC of effective width 7, 8, 16 or 32 bits.
module crc_byte_step
  import crc_mc_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  din,
  input  logic [31:0] poly,
  input  logic [1:0]  psize,
  output logic [31:0] crc_next
);

  logic [31:0] mask_s;
  logic [31:0] top_s;
  logic [31:0] poly_m_s;

  assign mask_s   = width_mask(psize);
  assign top_s    = top_bit(psize);
  assign poly_m_s = poly & mask_s;

  // Eight serial shifts, message bit MSB first
  always_comb begin
    crc_next = crc & mask_s;
    for (int i = 7; i >= 0; i--) begin
      if (((crc_next & top_s) != 32'h0) ^ din[i]) crc_next = ((crc_next << 1) & mask_s) ^ poly_m_s;
      else                                        crc_next = (crc_next << 1) & mask_s;
    end
  end

endmodule

// File: rtl/crc_unit_mc.sv
// Multi-channel CRC unit: N_CH contexts share one byte-per-cycle engine fed by an in-order command queue.
// Define CRC_MC_XOR_OUT_EN to add a per-channel final-XOR register applied to crc_out.
module crc_unit_mc
  import crc_mc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            data_valid,
  output logic            data_ready,
  input  logic [CH_W-1:0] data_ch,
  input  logic [31:0]     data,
  input  logic [1:0]      data_size,
  input  logic [1:0]      rev_in_type,
  input  logic            reset_chain,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [31:0]     cfg_wdata,
  input  logic            cfg_poly_en,
  input  logic            cfg_init_en,
  input  logic            cfg_xor_en,
  input  logic [1:0]      cfg_poly_size,
  output logic            cfg_busy,
  input  logic [CH_W-1:0] rd_ch,
  input  logic            rev_out_type,
  output logic [31:0]     crc_out,
  output logic            rd_wait,
  output logic            fifo_full,
  output logic            done,
  output logic [CH_W-1:0] done_ch
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH + 2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  entry_t          fifo_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_r;
  logic [PW-1:0]   pend_r [N_CH];
  logic [31:0]     poly_r [N_CH];
  logic [31:0]     init_r [N_CH];
  logic [31:0]     crc_r  [N_CH];
  logic [1:0]      psize_r[N_CH];
  state_e          state_r, state_s;
  cmd_e            cur_cmd_r;
  logic [CH_W-1:0] cur_ch_r;
  logic [31:0]     cur_data_r;
  logic [1:0]      idx_r;
  logic            done_r;
  logic [CH_W-1:0] done_ch_r;

  entry_t      push_entry_s, head_s;
  logic        fifo_full_s, push_s, pop_s, last_s, retire_s, cfg_busy_s, cfg_wr_s;
  logic [7:0]  cur_byte_s;
  logic [31:0] step_crc_s, eng_crc_s, rd_mask_s, rd_crc_s, rd_rev_s, crc_out_s;
  logic        unused_head_s;

  assign fifo_full_s = (count_r == (AW + 1)'(FIFO_DEPTH));
  assign push_s      = !fifo_full_s && (reset_chain || data_valid);
  assign head_s      = fifo_r[rd_ptr_r];
  assign unused_head_s = ^head_s;

  assign push_entry_s.cmd  = reset_chain ? CMD_RESET : CMD_DATA;
  assign push_entry_s.ch   = ENTRY_CH_W'(data_ch);
  assign push_entry_s.data = data;
  assign push_entry_s.size = data_size;
  assign push_entry_s.rev  = rev_in_type;

  assign cur_byte_s = cur_data_r[{idx_r, 3'b000} +: 8];
  assign last_s     = (cur_cmd_r == CMD_RESET) || (idx_r == 2'd0);
  assign retire_s   = (state_r == ST_RUN) && last_s;
  assign pop_s      = (count_r != (AW + 1)'(0)) && ((state_r == ST_IDLE) || retire_s);
  assign cfg_busy_s = (pend_r[cfg_ch] != PW'(0));
  assign cfg_wr_s   = !cfg_busy_s;

  crc_byte_step u_step (
    .crc      (crc_r[cur_ch_r]),
    .din      (cur_byte_s),
    .poly     (poly_r[cur_ch_r]),
    .psize    (psize_r[cur_ch_r]),
    .crc_next (step_crc_s)
  );

  // Value the engine writes back to the active channel this cycle
  always_comb begin
    eng_crc_s = step_crc_s;
    if (cur_cmd_r == CMD_RESET) eng_crc_s = init_r[cur_ch_r] & width_mask(psize_r[cur_ch_r]);
    else                        eng_crc_s = step_crc_s;
  end

  // Engine next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (retire_s && !pop_s) state_s = ST_IDLE;
        else                    state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Command queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= push_entry_s;
        wr_ptr_r         <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Engine state and the command currently being processed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cur_cmd_r  <= CMD_DATA;
      cur_ch_r   <= '0;
      cur_data_r <= 32'h0;
      idx_r      <= 2'd0;
    end else begin
      state_r <= state_s;
      if (pop_s) begin
        cur_cmd_r  <= head_s.cmd;
        cur_ch_r   <= head_s.ch[CH_W-1:0];
        cur_data_r <= in_reverse(head_s.data, head_s.size, head_s.rev);
        idx_r      <= last_byte_idx(head_s.size);
      end else if ((state_r == ST_RUN) && !last_s) begin
        idx_r <= idx_r - 2'd1;
      end
    end
  end

  // Per-channel pending counts cover both queued and in-flight commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) pend_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case ({push_s && (data_ch == CH_W'(i)), retire_s && (cur_ch_r == CH_W'(i))})
          2'b10:   pend_r[i] <= pend_r[i] + PW'(1);
          2'b01:   pend_r[i] <= pend_r[i] - PW'(1);
          default: pend_r[i] <= pend_r[i];
        endcase
      end
    end
  end

  // Channel contexts; cfg writes cannot collide with the engine since a busy channel blocks them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        poly_r[i]  <= RST_POLY;
        psize_r[i] <= RST_PSIZE;
        init_r[i]  <= RST_INIT;
        crc_r[i]   <= RST_CRC;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_wr_s && (cfg_ch == CH_W'(i)) && cfg_poly_en) begin
          poly_r[i]  <= cfg_wdata;
          psize_r[i] <= cfg_poly_size;
        end
        if (cfg_wr_s && (cfg_ch == CH_W'(i)) && cfg_init_en) init_r[i] <= cfg_wdata;
        if ((state_r == ST_RUN) && (cur_ch_r == CH_W'(i)))             crc_r[i] <= eng_crc_s;
        else if (cfg_wr_s && (cfg_ch == CH_W'(i)) && cfg_init_en)      crc_r[i] <= cfg_wdata;
      end
    end
  end

  // Retire pulse and channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r    <= 1'b0;
      done_ch_r <= '0;
    end else begin
      done_r <= retire_s;
      if (retire_s) done_ch_r <= cur_ch_r;
    end
  end

  assign rd_mask_s = width_mask(psize_r[rd_ch]);
  assign rd_crc_s  = crc_r[rd_ch] & rd_mask_s;
  assign rd_rev_s  = bit_rev32(rd_crc_s) >> (6'd32 - width_bits(psize_r[rd_ch]));

`ifdef CRC_MC_XOR_OUT_EN
  logic [31:0] xor_r [N_CH];

  // Final-XOR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) xor_r[i] <= RST_XOR;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_wr_s && (cfg_ch == CH_W'(i)) && cfg_xor_en) xor_r[i] <= cfg_wdata;
      end
    end
  end

  // Read path with reversal and final XOR
  always_comb begin
    crc_out_s = rd_crc_s;
    if (rev_out_type) crc_out_s = (rd_rev_s ^ xor_r[rd_ch]) & rd_mask_s;
    else              crc_out_s = (rd_crc_s ^ xor_r[rd_ch]) & rd_mask_s;
  end
`else
  logic unused_xor_en_s;
  assign unused_xor_en_s = cfg_xor_en;

  // Read path with optional reversal
  always_comb begin
    crc_out_s = rd_crc_s;
    if (rev_out_type) crc_out_s = rd_rev_s & rd_mask_s;
    else              crc_out_s = rd_crc_s;
  end
`endif

  assign crc_out    = crc_out_s;
  assign data_ready = !fifo_full_s;
  assign fifo_full  = fifo_full_s;
  assign cfg_busy   = cfg_busy_s;
  assign rd_wait    = (pend_r[rd_ch] != PW'(0));
  assign done       = done_r;
  assign done_ch    = done_ch_r;

endmodule

// File: tb/tb_crc_unit_mc.sv
// Directed bench for crc_unit_mc: reset values, CRC-32/CRC-8 vectors, queue full, reset priority, mid-command reset.
module tb_crc_unit_mc;

  localparam int N_CH       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 2;

  logic            clk, rst_n;
  logic            data_valid, data_ready, reset_chain;
  logic [CH_W-1:0] data_ch, cfg_ch, rd_ch, done_ch;
  logic [31:0]     data, cfg_wdata, crc_out;
  logic [1:0]      data_size, rev_in_type, cfg_poly_size;
  logic            cfg_poly_en, cfg_init_en, cfg_xor_en, cfg_busy;
  logic            rev_out_type, rd_wait, fifo_full, done;

  int n_checks = 0;
  int n_fails  = 0;

  crc_unit_mc #(.N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_valid(data_valid), .data_ready(data_ready), .data_ch(data_ch), .data(data),
    .data_size(data_size), .rev_in_type(rev_in_type), .reset_chain(reset_chain),
    .cfg_ch(cfg_ch), .cfg_wdata(cfg_wdata), .cfg_poly_en(cfg_poly_en), .cfg_init_en(cfg_init_en),
    .cfg_xor_en(cfg_xor_en), .cfg_poly_size(cfg_poly_size), .cfg_busy(cfg_busy),
    .rd_ch(rd_ch), .rev_out_type(rev_out_type), .crc_out(crc_out), .rd_wait(rd_wait),
    .fifo_full(fifo_full), .done(done), .done_ch(done_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_step(input logic [31:0] c_in, input logic [7:0] b,
                                         input logic [31:0] poly, input int w);
    logic [31:0] m, c;
    logic fb;
    c = c_in;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    for (int i = 7; i >= 0; i--) begin
      fb = c[w-1] ^ b[i];
      c  = (c << 1) & m;
      if (fb) c = c ^ (poly & m);
    end
    return c;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    c = c_in;
    for (int k = 3; k >= 0; k--) c = m_step(c, d[8*k +: 8], 32'h04C1_1DB7, 32);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    data_valid = 1'b0; reset_chain = 1'b0; data_ch = '0; data = 32'h0;
    data_size = 2'b00; rev_in_type = 2'b00; cfg_ch = '0; cfg_wdata = 32'h0;
    cfg_poly_en = 1'b0; cfg_init_en = 1'b0; cfg_xor_en = 1'b0; cfg_poly_size = 2'b00;
    rd_ch = '0; rev_out_type = 1'b0;
  endtask

  task automatic push(input logic [CH_W-1:0] ch, input logic [31:0] d, input logic [1:0] sz,
                      input logic [1:0] rv);
    int n;
    n = 0;
    while (!data_ready && n < 50) begin tick(); n++; end
    if (!data_ready) begin
      n_checks++; n_fails++;
      $display("FAIL push_ready_timeout: data_ready=%0b required 1", data_ready);
    end
    data_valid = 1'b1; data_ch = ch; data = d; data_size = sz; rev_in_type = rv;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_quiet(input logic [CH_W-1:0] ch);
    int n;
    rd_ch = ch; #1;
    n = 0;
    while (rd_wait && n < 200) begin tick(); n++; end
    n_checks++;
    if (rd_wait !== 1'b0) begin
      n_fails++;
      $display("FAIL wait_quiet_ch%0d: rd_wait=%0b required 0", ch, rd_wait);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (data_ready !== 1'b1) begin n_fails++; $display("FAIL rst_data_ready: got %0b want 1", data_ready); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fails++; $display("FAIL rst_fifo_full: got %0b want 0", fifo_full); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fails++; $display("FAIL rst_cfg_busy: got %0b want 0", cfg_busy); end
    n_checks++; if (rd_wait !== 1'b0) begin n_fails++; $display("FAIL rst_rd_wait: got %0b want 0", rd_wait); end
    n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL rst_done: got %0b want 0", done); end
    n_checks++; if (done_ch !== 2'd0) begin n_fails++; $display("FAIL rst_done_ch: got %0d want 0", done_ch); end
    n_checks++; if (crc_out !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL rst_crc_out: got %h want ffffffff", crc_out); end
  endtask

  task automatic test_crc32_zero_word();
    bit seen;
    rd_ch = 2'd0;
    push(2'd0, 32'h0000_0000, 2'b10, 2'b00);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    n_checks++; if (!seen) begin n_fails++; $display("FAIL basic_done_timeout: done=%0b want 1", done); end
    n_checks++; if (done_ch !== 2'd0) begin n_fails++; $display("FAIL basic_done_ch: got %0d want 0", done_ch); end
    n_checks++; if (crc_out !== 32'hC704_DD7B) begin n_fails++; $display("FAIL basic_crc: got %h want c704dd7b", crc_out); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL basic_done_pulse: got %0b want 0", done); end
  endtask

  task automatic test_crc8_interleave();
    logic [31:0] exp2, w;
    cfg_ch = 2'd1; cfg_wdata = 32'h0000_0007; cfg_poly_size = 2'b10; cfg_poly_en = 1'b1;
    tick();
    cfg_poly_en = 1'b0; cfg_wdata = 32'h0000_0000; cfg_init_en = 1'b1;
    tick();
    cfg_init_en = 1'b0;
    rd_ch = 2'd1; #1;
    n_checks++; if (crc_out !== 32'h0000_0000) begin n_fails++; $display("FAIL crc8_init_load: got %h want 00000000", crc_out); end
    exp2 = 32'hFFFF_FFFF;
    for (int k = 0; k < 9; k++) begin
      push(2'd1, 32'h31 + 32'(k), 2'b00, 2'b00);
      if (k == 0) begin
        cfg_ch = 2'd1; #1;
        n_checks++; if (cfg_busy !== 1'b1) begin n_fails++; $display("FAIL crc8_cfg_busy: got %0b want 1", cfg_busy); end
        cfg_wdata = 32'h0000_001D; cfg_poly_size = 2'b10; cfg_poly_en = 1'b1;
        tick();
        cfg_poly_en = 1'b0;
      end
      if (k == 2 || k == 5) begin
        w = (k == 2) ? 32'hDEAD_BEEF : 32'h1234_5678;
        push(2'd2, w, 2'b10, 2'b00);
        exp2 = m_word(exp2, w);
      end
    end
    wait_quiet(2'd1);
    wait_quiet(2'd2);
    rd_ch = 2'd1; #1;
    n_checks++; if (crc_out !== 32'h0000_00F4) begin n_fails++; $display("FAIL crc8_check: got %h want 000000f4", crc_out); end
    rd_ch = 2'd2; #1;
    n_checks++; if (crc_out !== exp2) begin n_fails++; $display("FAIL ch2_isolated: got %h want %h", crc_out, exp2); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp3, w;
    int acc, retires, busy_err;
    rd_ch = 2'd3; cfg_ch = 2'd3;
    acc = 0; exp3 = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      if (!data_ready) break;
      w = 32'h1111_1111 * 32'(k + 1);
      data_valid = 1'b1; data_ch = 2'd3; data = w; data_size = 2'b10; rev_in_type = 2'b00;
      acc++;
      exp3 = m_word(exp3, w);
      tick();
    end
    data = 32'hBAD0_BAD0;
    n_checks++; if (acc !== 5) begin n_fails++; $display("FAIL full_accepted: got %0d want 5", acc); end
    n_checks++; if (fifo_full !== 1'b1) begin n_fails++; $display("FAIL full_flag: got %0b want 1", fifo_full); end
    n_checks++; if (data_ready !== 1'b0) begin n_fails++; $display("FAIL full_ready: got %0b want 0", data_ready); end
    tick();
    data_valid = 1'b0;
    retires = 0; busy_err = 0;
    for (int n = 0; n < 60; n++) begin
      if (done && done_ch == 2'd3) retires++;
      if (retires < acc && (!rd_wait || !cfg_busy)) busy_err++;
      tick();
    end
    n_checks++; if (retires !== acc) begin n_fails++; $display("FAIL full_retires: got %0d want %0d", retires, acc); end
    n_checks++; if (busy_err !== 0) begin n_fails++; $display("FAIL full_busy_held: got %0d early drops want 0", busy_err); end
    n_checks++; if (rd_wait !== 1'b0 || cfg_busy !== 1'b0) begin n_fails++; $display("FAIL full_idle: rd_wait=%0b cfg_busy=%0b want 0 0", rd_wait, cfg_busy); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fails++; $display("FAIL full_drained: got %0b want 0", fifo_full); end
    n_checks++; if (crc_out !== exp3) begin n_fails++; $display("FAIL full_crc: got %h want %h", crc_out, exp3); end
  endtask

  task automatic test_reset_priority();
    int dn;
    rd_ch = 2'd0;
    data_ch = 2'd0; data = 32'h1234_5678; data_size = 2'b10; rev_in_type = 2'b00;
    reset_chain = 1'b1; data_valid = 1'b1;
    tick();
    reset_chain = 1'b0; data_valid = 1'b0;
    dn = 0;
    for (int n = 0; n < 20; n++) begin
      if (done && done_ch == 2'd0) dn++;
      tick();
    end
    n_checks++; if (dn !== 1) begin n_fails++; $display("FAIL prio_retires: got %0d want 1", dn); end
    n_checks++; if (crc_out !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL prio_crc: got %h want ffffffff", crc_out); end
    n_checks++; if (rd_wait !== 1'b0) begin n_fails++; $display("FAIL prio_rd_wait: got %0b want 0", rd_wait); end
  endtask

  task automatic test_reflected_xor();
    logic [31:0] exp;
    cfg_ch = 2'd0; cfg_wdata = 32'hFFFF_FFFF; cfg_xor_en = 1'b1;
    tick();
    cfg_xor_en = 1'b0;
    for (int k = 0; k < 9; k++) push(2'd0, 32'h31 + 32'(k), 2'b00, 2'b01);
    wait_quiet(2'd0);
    rev_out_type = 1'b1; #1;
`ifdef CRC_MC_XOR_OUT_EN
    exp = 32'hCBF4_3926;
`else
    exp = 32'h340B_C6D9;
`endif
    n_checks++; if (crc_out !== exp) begin n_fails++; $display("FAIL reflected_crc32: got %h want %h", crc_out, exp); end
    rev_out_type = 1'b0;
  endtask

  task automatic test_mid_reset();
    int quiet_err;
    push(2'd1, 32'hA5A5_A5A5, 2'b10, 2'b00);
    push(2'd0, 32'h5A5A_5A5A, 2'b10, 2'b00);
    push(2'd2, 32'h0F0F_0F0F, 2'b10, 2'b00);
    tick();
    rst_n = 1'b0; #1;
    rd_ch = 2'd0; cfg_ch = 2'd1; rev_out_type = 1'b0; #1;
    n_checks++; if (data_ready !== 1'b1) begin n_fails++; $display("FAIL mid_data_ready: got %0b want 1", data_ready); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fails++; $display("FAIL mid_fifo_full: got %0b want 0", fifo_full); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fails++; $display("FAIL mid_cfg_busy: got %0b want 0", cfg_busy); end
    n_checks++; if (rd_wait !== 1'b0) begin n_fails++; $display("FAIL mid_rd_wait: got %0b want 0", rd_wait); end
    n_checks++; if (done !== 1'b0 || done_ch !== 2'd0) begin n_fails++; $display("FAIL mid_done: got %0b/%0d want 0/0", done, done_ch); end
    n_checks++; if (crc_out !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL mid_crc_ch0: got %h want ffffffff", crc_out); end
    #2;
    rst_n = 1'b1;
    quiet_err = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done || rd_wait || fifo_full) quiet_err++;
    end
    n_checks++; if (quiet_err !== 0) begin n_fails++; $display("FAIL mid_queue_empty: got %0d busy cycles want 0", quiet_err); end
    rd_ch = 2'd1; #1;
    n_checks++; if (crc_out !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL mid_crc_ch1: got %h want ffffffff", crc_out); end
  endtask

  initial begin
    test_reset();
    test_crc32_zero_word();
    test_crc8_interleave();
    test_fifo_full();
    test_reset_priority();
    test_reflected_xor();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
